tlk2711_tx_cmd_mq: RTL

Parametrised multi-channel TX command generator for the TLK2711 transmit path. Software loads frame descriptors (address, byte length, channel) through the 12-bit register bus into a descriptor queue. The block pops one frame at a time and publishes its packet geometry to the TX framer with a start pulse. It splits the frame into DataMover read commands of at most PKT_BYTES each, then waits for the framer's completion before starting the next frame. Mode-control handshake to the transceiver is retained.

---
 rtl/tlk2711_tx_cmd_mq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tlk2711_tx_cmd_mq.sv
// tlk2711_tx_cmd_mq: descriptor-queued TX frame sequencer issuing DataMover read commands per packet
module tlk2711_tx_cmd_mq #(
  parameter int NUM_CH = 4,
  parameter int QDEPTH = 8,
  parameter int PKT_BYTES = 2048,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(QDEPTH) + 1,
  localparam int TAIL_W = $clog2(PKT_BYTES)
) (
  input  logic              i_clk,
  input  logic              i_soft_rst,
  input  logic [31:0]       i_reg_wdata,
  input  logic [11:0]       i_reg_waddr,
  input  logic              i_reg_wen,
  input  logic              i_reg_ren,
  input  logic [11:0]       i_reg_raddr,
  output logic [31:0]       o_reg_rdata,
  output logic              o_reg_valid,
  output logic [2:0]        o_mode,
  output logic              o_mode_set,
  output logic              o_mode_rst,
  input  logic [2:0]        i_mode,
  input  logic              i_dma_rdcmd_ready,
  output logic [71:0]       o_dma_rdcmd_data,
  output logic              o_dma_rdcmd_valid,
  output logic [31:0]       o_packet_body,
  output logic [TAIL_W-1:0] o_packet_tail,
  output logic [CH_W-1:0]   o_send_ch,
  output logic              o_send_start,
  input  logic              i_tx_done,
  output logic              o_busy
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [22:0] PKT = 23'(PKT_BYTES);
  typedef enum logic [2:0] {IDLE, LOAD, START, CMD, WAIT_DONE} state_t;
  state_t state;
  logic [31:0] q_addr [QDEPTH];
  logic [22:0] q_len [QDEPTH];
  logic [CH_W-1:0] q_ch [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [31:0] desc_addr, cur_addr, frame_cnt, status, rd_mux;
  logic [22:0] desc_len, rem, btt;
  logic ovf, bad_len, bad_ch, done_pend, eof;
  logic wr_ctrl, push, full, empty, len_bad, ch_bad, do_push, do_pop, flush, clr;
  assign wr_ctrl = i_reg_wen && i_reg_waddr == 12'h000;
  assign push = i_reg_wen && i_reg_waddr == 12'h00c;
  assign full = level == LVL_W'(QDEPTH);
  assign empty = level == '0;
  assign len_bad = desc_len == '0;
  assign ch_bad = 32'(i_reg_wdata[3:0]) >= NUM_CH;
  assign do_push = push && !len_bad && !ch_bad && !full;
  assign do_pop = state == LOAD && !empty;
  assign flush = wr_ctrl && i_reg_wdata[16];
  assign clr = wr_ctrl && i_reg_wdata[17];
  assign btt = rem > PKT ? PKT : rem;
  assign eof = rem <= PKT;
  assign o_busy = state != IDLE;
  // Command fields are derived from the live frame counters; gating keeps the bus quiet when idle.
  assign o_dma_rdcmd_data = o_dma_rdcmd_valid ?
    {4'd0, 4'(o_send_ch), cur_addr, 1'b0, eof, 6'd0, 1'b1, btt} : '0;
  always_comb begin
    status = '0;
    status[2:0] = i_mode;
    status[8] = o_busy;
    status[9] = full;
    status[10] = empty;
    status[16 +: LVL_W] = level;
    status[24] = ovf;
    status[25] = bad_len;
    status[26] = bad_ch;
    rd_mux = i_reg_raddr == 12'h004 ? desc_addr :
             i_reg_raddr == 12'h008 ? {9'd0, desc_len} :
             i_reg_raddr == 12'h010 ? status :
             i_reg_raddr == 12'h014 ? frame_cnt : '0;
  end
  always_ff @(posedge i_clk)
    if (do_push) begin
      q_addr[wr_ptr] <= desc_addr;
      q_len[wr_ptr] <= desc_len;
      q_ch[wr_ptr] <= i_reg_wdata[CH_W-1:0];
    end
  always_ff @(posedge i_clk) begin
    if (i_soft_rst) begin
      state <= IDLE;
      o_reg_rdata <= '0;
      o_reg_valid <= 1'b0;
      o_mode <= '0;
      o_mode_set <= 1'b0;
      o_mode_rst <= 1'b0;
      o_dma_rdcmd_valid <= 1'b0;
      o_packet_body <= '0;
      o_packet_tail <= '0;
      o_send_ch <= '0;
      o_send_start <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      desc_addr <= '0;
      desc_len <= '0;
      cur_addr <= '0;
      rem <= '0;
      frame_cnt <= '0;
      ovf <= 1'b0;
      bad_len <= 1'b0;
      bad_ch <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      o_reg_valid <= i_reg_ren;
      o_reg_rdata <= i_reg_ren ? rd_mux : '0;
      o_mode <= wr_ctrl ? i_reg_wdata[2:0] : o_mode;
      o_mode_set <= wr_ctrl && i_reg_wdata[8];
      o_mode_rst <= wr_ctrl && i_reg_wdata[9];
      if (i_reg_wen && i_reg_waddr == 12'h004) desc_addr <= i_reg_wdata;
      if (i_reg_wen && i_reg_waddr == 12'h008) desc_len <= i_reg_wdata[22:0];
      ovf <= clr ? 1'b0 : ovf | (push && full);
      bad_len <= clr ? 1'b0 : bad_len | (push && len_bad);
      bad_ch <= clr ? 1'b0 : bad_ch | (push && ch_bad);
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= flush ? wr_ptr : rd_ptr + PW'(do_pop);
      level <= flush ? '0 : level + LVL_W'(do_push) - LVL_W'(do_pop);
      if (state == CMD && i_tx_done) done_pend <= 1'b1;
      case (state)
        IDLE: if (!empty) state <= LOAD;
        LOAD:
          if (empty) state <= IDLE;
          else begin
            o_packet_body <= 32'(q_len[rd_ptr] >> TAIL_W);
            o_packet_tail <= q_len[rd_ptr][TAIL_W-1:0];
            o_send_ch <= q_ch[rd_ptr];
            cur_addr <= q_addr[rd_ptr];
            rem <= q_len[rd_ptr];
            o_send_start <= 1'b1;
            state <= START;
          end
        START: begin
          o_send_start <= 1'b0;
          o_dma_rdcmd_valid <= 1'b1;
          state <= CMD;
        end
        CMD:
          if (i_dma_rdcmd_ready) begin
            cur_addr <= cur_addr + 32'(btt);
            rem <= rem - btt;
            if (eof) begin
              o_dma_rdcmd_valid <= 1'b0;
              state <= WAIT_DONE;
            end
          end
        WAIT_DONE:
          if (done_pend || i_tx_done) begin
            frame_cnt <= frame_cnt + 32'd1;
            done_pend <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
